// File: rtl/mem_port_sequencer.sv
// Shared memory-port sequencer for the multicycle CPU: arbitrates fetch, data and
// exception-vector reads, steps each access through the fixed memory latency.
module mem_port_sequencer #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned CNT_W   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fetch_req,
   input  logic       data_req,
   input  logic       data_we,
   input  logic       exc_req,
   input  logic       exc_sel,
   output logic [1:0] iord_control,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       fetch_done,
   output logic       data_done,
   output logic       exc_done,
   output logic       busy
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ACCESS   = 2'd1;
   localparam logic [1:0] S_WAIT     = 2'd2;
   localparam logic [1:0] S_COMPLETE = 2'd3;

   localparam logic [1:0] SRC_PC  = 2'b00;
   localparam logic [1:0] SRC_ALU = 2'b01;
   localparam logic [1:0] SRC_OVF = 2'b10;
   localparam logic [1:0] SRC_INV = 2'b11;

   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

   logic [1:0]       state_q, state_d;
   logic [1:0]       src_q, src_d;
   logic             store_q, store_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0] iord_d;
   logic       mem_wr_d, ir_write_d, mdr_write_d;
   logic       fetch_done_d, data_done_d, exc_done_d, busy_d;
   logic       is_fetch, is_data, is_exc, in_complete;

   // The latched address-source code doubles as the record of which requester won.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      store_d = store_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (exc_req) begin
               state_d = S_ACCESS;
               src_d   = exc_sel ? SRC_INV : SRC_OVF;
               store_d = 1'b0;
            end else if (data_req) begin
               state_d = S_ACCESS;
               src_d   = SRC_ALU;
               store_d = data_we;
            end else if (fetch_req) begin
               state_d = S_ACCESS;
               src_d   = SRC_PC;
               store_d = 1'b0;
            end
         end
         S_ACCESS: begin
            cnt_d = LAT;
            if (MEM_LAT == 0) begin
               state_d = S_COMPLETE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_COMPLETE;
            end
         end
         S_COMPLETE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered, so they are decoded from the next state and next latch.
   always_comb begin
      is_fetch     = (src_d == SRC_PC);
      is_data      = (src_d == SRC_ALU);
      is_exc       = src_d[1];
      in_complete  = (state_d == S_COMPLETE);
      busy_d       = (state_d != S_IDLE);
      iord_d       = busy_d ? src_d : SRC_PC;
      mem_wr_d     = (state_d == S_ACCESS) && is_data && store_d;
      ir_write_d   = in_complete && is_fetch;
      mdr_write_d  = in_complete && (is_exc || (is_data && !store_d));
      fetch_done_d = in_complete && is_fetch;
      data_done_d  = in_complete && is_data;
      exc_done_d   = in_complete && is_exc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         src_q        <= SRC_PC;
         store_q      <= 1'b0;
         cnt_q        <= '0;
         iord_control <= SRC_PC;
         mem_wr       <= 1'b0;
         ir_write     <= 1'b0;
         mdr_write    <= 1'b0;
         fetch_done   <= 1'b0;
         data_done    <= 1'b0;
         exc_done     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         store_q      <= store_d;
         cnt_q        <= cnt_d;
         iord_control <= iord_d;
         mem_wr       <= mem_wr_d;
         ir_write     <= ir_write_d;
         mdr_write    <= mdr_write_d;
         fetch_done   <= fetch_done_d;
         data_done    <= data_done_d;
         exc_done     <= exc_done_d;
         busy         <= busy_d;
      end
   end

endmodule
